// File: rtl/mem_load_unit_pkg.sv
// Shared load-unit constants: XLEN/type-width defaults and MEM_* load codes.
// mem_bytes() maps a load code to its access size in bytes (0 = illegal).
package mem_load_unit_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int MEM_TYPE_LEN_DEF = 3;
  localparam int TAG_LEN_DEF      = 5;

  localparam int MEM_B  = 0;
  localparam int MEM_H  = 1;
  localparam int MEM_W  = 2;
  localparam int MEM_D  = 3;
  localparam int MEM_BU = 4;
  localparam int MEM_HU = 5;
  localparam int MEM_WU = 6;

  function automatic int mem_bytes(
    input int code,
    input int xlen
  );
    int n;
    n = 0;
    case (code)
      MEM_B, MEM_BU: n = 1;
      MEM_H, MEM_HU: n = 2;
      MEM_W:         n = 4;
      MEM_WU:        n = (xlen == 64) ? 4 : 0;
      MEM_D:         n = (xlen == 64) ? 8 : 0;
      default:       n = 0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_load_unit_extract.sv
// load_extract: aligns {beat1,beat0} by byte offset, masks and extends.
// Ports: beat0/beat1 data words, offset, mem_type in; result out.
module load_extract
  import mem_load_unit_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int MEM_TYPE_LEN = MEM_TYPE_LEN_DEF
) (
  input  logic [XLEN-1:0]            beat0,
  input  logic [XLEN-1:0]            beat1,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [MEM_TYPE_LEN-1:0]    mem_type,
  output logic [XLEN-1:0]            result
);

  logic [XLEN-1:0] win;

  assign win = XLEN'({beat1, beat0} >> {offset, 3'b000});

  // Keep the low `bits` bits; shift up then back down to extend.
  function automatic logic [XLEN-1:0] ext(
    input logic [XLEN-1:0] v,
    input int              bits,
    input logic            sgn
  );
    logic        [XLEN-1:0] up;
    logic signed [XLEN-1:0] s;
    up = v << (XLEN - bits);
    s  = $signed(up) >>> (XLEN - bits);
    if (sgn) return s;
    return up >> (XLEN - bits);
  endfunction

  always_comb begin
    result = win;
    case (int'(mem_type))
      MEM_B:   result = ext(win, 8, 1'b1);
      MEM_BU:  result = ext(win, 8, 1'b0);
      MEM_H:   result = ext(win, 16, 1'b1);
      MEM_HU:  result = ext(win, 16, 1'b0);
      MEM_W:   result = ext(win, 32, 1'b1);
      MEM_WU:  result = ext(win, 32, 1'b0);
      default: result = win;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Load unit: accepts a load, issues 1-2 word reads, returns aligned data.
// Ports: req_* in, mem_req_*/mem_resp_* to memory, rsp_* out.
// Macro MEM_LOAD_MISALIGNED_EN enables word-crossing loads; else they fault.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int MEM_TYPE_LEN = MEM_TYPE_LEN_DEF,
  parameter int TAG_LEN      = TAG_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [XLEN-1:0]         req_addr,
  input  logic [MEM_TYPE_LEN-1:0] req_type,
  input  logic [TAG_LEN-1:0]      req_tag,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [XLEN-1:0]         mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [XLEN-1:0]         mem_resp_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [XLEN-1:0]         rsp_data,
  output logic [TAG_LEN-1:0]      rsp_tag,
  output logic                    rsp_fault
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [OFF_W-1:0]        off_q;
  logic [MEM_TYPE_LEN-1:0] type_q;
  logic [TAG_LEN-1:0]      tag_q;
  logic                    split_q;
  logic                    fault_q;
  logic                    beat_idx_q;
  logic [XLEN-1:0]         mem_addr_q;
  logic [XLEN-1:0]         beat0_q;
  logic [XLEN-1:0]         beat1_q;
  logic [XLEN-1:0]         ext_data;

  logic [OFF_W-1:0] acc_off;
  logic [XLEN-1:0]  acc_word;
  int               acc_bytes;
  logic             acc_split;
  logic             acc_fault;
  logic             split_fault;
  logic             accept;
  logic             beat_in;

  assign acc_off   = req_addr[OFF_W-1:0];
  assign acc_word  = {req_addr[XLEN-1:OFF_W], OFF_W'(0)};
  assign acc_bytes = mem_bytes(int'(req_type), XLEN);
  assign acc_split = (int'(acc_off) + acc_bytes) > NB;

`ifdef MEM_LOAD_MISALIGNED_EN
  assign split_fault = 1'b0;
`else
  assign split_fault = acc_split;
`endif

  assign acc_fault = (acc_bytes == 0) || split_fault;
  assign accept    = (state_q == IDLE) && req_valid;
  assign beat_in   = (state_q == WAIT) && mem_resp_valid;

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    rsp_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = acc_fault ? DONE : REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready)
          state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid)
          state_d = (split_q && !beat_idx_q)
                  ? REQ : DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      off_q      <= '0;
      type_q     <= '0;
      tag_q      <= '0;
      split_q    <= 1'b0;
      fault_q    <= 1'b0;
      beat_idx_q <= 1'b0;
      mem_addr_q <= '0;
      beat0_q    <= '0;
      beat1_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q      <= acc_off;
        type_q     <= req_type;
        tag_q      <= req_tag;
        split_q    <= acc_split;
        fault_q    <= acc_fault;
        beat_idx_q <= 1'b0;
        mem_addr_q <= acc_word;
        beat0_q    <= '0;
        beat1_q    <= '0;
      end
      if (beat_in) begin
        if (!beat_idx_q)
          beat0_q <= mem_resp_data;
        else
          beat1_q <= mem_resp_data;
        if (split_q && !beat_idx_q) begin
          beat_idx_q <= 1'b1;
          mem_addr_q <= mem_addr_q + XLEN'(NB);
        end
      end
    end
  end

  load_extract #(
    .XLEN         (XLEN),
    .MEM_TYPE_LEN (MEM_TYPE_LEN)
  ) u_extract (
    .beat0    (beat0_q),
    .beat1    (beat1_q),
    .offset   (off_q),
    .mem_type (type_q),
    .result   (ext_data)
  );

  assign mem_req_addr = mem_addr_q;
  assign rsp_tag      = tag_q;
  assign rsp_fault    = (state_q == DONE) && fault_q;
  assign rsp_data     = (state_q == DONE && !fault_q)
                      ? ext_data : '0;

endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit (XLEN=32): directed and random loads checked
// against a byte-level reference model of little-endian memory.
module tb_mem_load_unit;
  import mem_load_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [4:0]  req_tag;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        rsp_fault;

  mem_load_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_type       (req_type),
    .req_tag        (req_tag),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_tag        (rsp_tag),
    .rsp_fault      (rsp_fault)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem_words [logic [31:0]];

  logic [31:0] o_data;
  logic [31:0] o_addr0;
  logic        o_fault;
  logic [4:0]  o_tag;
  int          o_nreq;
  int          o_req_lat;
  int          o_rsp_lat;

  task automatic chk(
    input string       name,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             name, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_words.exists(w)) return mem_words[w];
    return (w * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_rd(a);
    return w[8*a[1:0] +: 8];
  endfunction

  // Reference: gather `size` bytes little-endian, then extend.
  task automatic model(
    input  logic [31:0] a,
    input  int          t,
    output logic [31:0] d,
    output logic        f,
    output int          n
  );
    int          size;
    bit          sgn;
    bit          split;
    logic [31:0] v;
    size = 0;
    sgn  = 0;
    case (t)
      MEM_B:   begin size = 1; sgn = 1; end
      MEM_H:   begin size = 2; sgn = 1; end
      MEM_W:   begin size = 4; sgn = 1; end
      MEM_BU:  size = 1;
      MEM_HU:  size = 2;
      default: size = 0;
    endcase
    split = (int'(a[1:0]) + size) > 4;
    f = (size == 0);
`ifndef MEM_LOAD_MISALIGNED_EN
    if (split) f = 1'b1;
`endif
    v = '0;
    n = 0;
    if (!f) begin
      for (int i = 0; i < size; i++)
        v[8*i +: 8] = mem_byte(a + 32'(i));
      if (sgn)
        for (int i = 8*size; i < 32; i++)
          v[i] = v[8*size-1];
      n = split ? 2 : 1;
    end
    d = v;
  endtask

  task automatic do_load(
    input logic [31:0] a,
    input int          t,
    input logic [4:0]  tg,
    input int          rs,
    input int          ps
  );
    bit          done;
    bit          pend;
    bit          hold_req;
    bit          hold_rsp;
    logic [31:0] paddr;
    logic [31:0] haddr;
    logic [31:0] hd;
    logic        hf;
    logic [4:0]  ht;
    int          t_drive;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    req_type  = 3'(t);
    req_tag   = tg;
    o_nreq    = 0;
    o_req_lat = -1;
    o_rsp_lat = -1;
    o_addr0   = '0;
    o_data    = '0;
    o_fault   = 1'b0;
    o_tag     = '0;
    done      = 0;
    pend      = 0;
    hold_req  = 0;
    hold_rsp  = 0;
    t_drive   = 0;
    paddr     = '0;
    haddr     = '0;
    hd        = '0;
    hf        = 1'b0;
    ht        = '0;
    for (int cyc = 1; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      req_valid      = 1'b0;
      req_addr       = $urandom;
      req_type       = 3'($urandom);
      req_tag        = 5'($urandom);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      rsp_ready      = 1'b0;
      if (pend) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_rd(paddr);
        pend    = 0;
        t_drive = cyc;
      end
      if (mem_req_valid) begin
        if (o_req_lat < 0) o_req_lat = cyc;
        if (o_nreq == 0) o_addr0 = mem_req_addr;
        if (hold_req)
          chk("mem_req_addr_stable", mem_req_addr, haddr);
        if (rs > 0) begin
          rs--;
          hold_req = 1;
          haddr    = mem_req_addr;
        end else begin
          mem_req_ready = 1'b1;
          hold_req = 0;
          o_nreq++;
          pend  = 1;
          paddr = mem_req_addr;
        end
      end
      if (rsp_valid) begin
        if (o_rsp_lat < 0) o_rsp_lat = cyc - t_drive;
        if (hold_rsp) begin
          chk("rsp_data_stable", rsp_data, hd);
          chk("rsp_tag_stable", rsp_tag, ht);
          chk("rsp_fault_stable", rsp_fault, hf);
        end
        if (ps > 0) begin
          ps--;
          hold_rsp = 1;
          hd = rsp_data;
          ht = rsp_tag;
          hf = rsp_fault;
        end else begin
          rsp_ready = 1'b1;
          o_data    = rsp_data;
          o_fault   = rsp_fault;
          o_tag     = rsp_tag;
          done      = 1;
          // new request offered in the same cycle as rsp handshake
          req_valid = 1'b1;
        end
      end
    end
    if (!done) chk("load_timeout", 1'b0, 1'b1);
    @(negedge clk);
    req_valid      = 1'b0;
    rsp_ready      = 1'b0;
    mem_resp_valid = 1'b0;
    chk("single_response", rsp_valid, 1'b0);
    chk("overlap_not_accepted", mem_req_valid, 1'b0);
    chk("idle_after_rsp", req_ready, 1'b1);
  endtask

  task automatic check_load(
    input logic [31:0] a,
    input int          t,
    input logic [4:0]  tg,
    input int          rs,
    input int          ps
  );
    logic [31:0] ed;
    logic        ef;
    int          en;
    model(a, t, ed, ef, en);
    do_load(a, t, tg, rs, ps);
    chk("data", o_data, ed);
    chk("fault", o_fault, ef);
    chk("tag", o_tag, tg);
    chk("nreq", o_nreq, en);
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_mem_req_addr", mem_req_addr, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_tag", rsp_tag, 5'h0);
    chk("rst_rsp_fault", rsp_fault, 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_type       = '0;
    req_tag        = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    rsp_ready      = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals();

    // LB sign-extend, word-aligned request address, latency
    mem_words[32'h1000] = 32'h8011_2233;
    do_load(32'h1003, MEM_B, 5'h03, 0, 0);
    chk("lb_data", o_data, 32'hFFFF_FF80);
    chk("lb_addr", o_addr0, 32'h1000);
    chk("lb_fault", o_fault, 1'b0);
    chk("lb_req_lat", o_req_lat, 1);
    chk("lb_rsp_lat", o_rsp_lat, 1);
    chk("lb_nreq", o_nreq, 1);

    // LHU upper half
    mem_words[32'h2000] = 32'hBEEF_1234;
    do_load(32'h2002, MEM_HU, 5'h04, 0, 0);
    chk("lhu_data", o_data, 32'h0000_BEEF);
    chk("lhu_fault", o_fault, 1'b0);

    // misaligned, not crossing a word
    do_load(32'h2001, MEM_H, 5'h05, 0, 0);
    chk("lh_mis_data", o_data, 32'hFFFF_EF12);
    chk("lh_mis_fault", o_fault, 1'b0);

    // word-crossing LW
    mem_words[32'h3000] = 32'h4433_2211;
    mem_words[32'h3004] = 32'h8877_6655;
    do_load(32'h3002, MEM_W, 5'h06, 0, 0);
`ifdef MEM_LOAD_MISALIGNED_EN
    chk("lw_split_data", o_data, 32'h6655_4433);
    chk("lw_split_nreq", o_nreq, 2);
    chk("lw_split_fault", o_fault, 1'b0);
`else
    chk("lw_split_data", o_data, 32'h0);
    chk("lw_split_nreq", o_nreq, 0);
    chk("lw_split_fault", o_fault, 1'b1);
`endif

    // illegal types for XLEN=32
    do_load(32'h3000, MEM_D, 5'h07, 0, 0);
    chk("ld_fault", o_fault, 1'b1);
    chk("ld_data", o_data, 32'h0);
    chk("ld_nreq", o_nreq, 0);
    do_load(32'h3000, MEM_WU, 5'h08, 0, 0);
    chk("lwu_fault", o_fault, 1'b1);
    do_load(32'h3000, 7, 5'h09, 0, 0);
    chk("undef_fault", o_fault, 1'b1);
    chk("undef_nreq", o_nreq, 0);

    // back-pressure on both sides
    mem_words[32'h5000] = 32'hCAFE_F00D;
    do_load(32'h5000, MEM_W, 5'h1A, 3, 2);
    chk("stall_data", o_data, 32'hCAFE_F00D);
    chk("stall_tag", o_tag, 5'h1A);
    chk("stall_nreq", o_nreq, 1);
    chk("stall_addr", o_addr0, 32'h5000);

    // randomized loads against the model
    for (int k = 0; k < 40; k++) begin
      check_load(32'h4000 + 32'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)),
                 5'($urandom),
                 int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)));
    end

    // reset while waiting for read data; late response ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h1000;
    req_type  = 3'(MEM_W);
    req_tag   = 5'h11;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_req", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rst_mid_wait", mem_req_valid, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk_reset_vals();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 1'b0);
    end

    // unit usable after the abandoned access
    check_load(32'h1000, MEM_W, 5'h12, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
